// File: rtl/alu_issue_stage.sv
// ID/EX stage register of the MIPS pipeline: decodes opcode/funct into the ALU
// control code, selects/extends operands and registers them for the EX-stage ALU.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt_in,
    input  logic [15:0]       imm16,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              stall,
    input  logic              flush,
    input  logic              clr_illegal,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [CTRL_W-1:0] ALU_Control,
    output logic [4:0]        shamt,
    output logic              ex_valid,
    output logic              ovf_en,
    output logic              illegal,
    output logic              illegal_seen
);
    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0011);
    localparam logic [CTRL_W-1:0] OP_SLL = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] OP_SRL = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] OP_SRA = CTRL_W'(4'b0110);
    localparam logic [CTRL_W-1:0] OP_LUI = CTRL_W'(4'b0111);
    localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(4'b1000);

    function automatic logic signed [DATA_W-1:0] sign_ext(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    function automatic logic signed [DATA_W-1:0] zero_ext(input logic [15:0] v);
        return {{(DATA_W-16){1'b0}}, v};
    endfunction

    logic signed [DATA_W-1:0] dec_a, dec_b;
    logic [CTRL_W-1:0]        dec_ctrl;
    logic [4:0]               dec_shamt;
    logic                     dec_ovf, dec_illegal, legal;

    // Stage p0: combinational decode of the ID-stage instruction
    always_comb begin
        legal     = 1'b1;
        dec_ctrl  = OP_ADD;
        dec_a     = rs_data;
        dec_b     = rt_data;
        dec_shamt = 5'd0;
        dec_ovf   = 1'b0;
        case (opcode)
            6'h00: begin
                dec_shamt = shamt_in;
                case (funct)
                    6'h20: dec_ovf = 1'b1;
                    6'h21: ;
                    6'h22: begin dec_ctrl = OP_SUB; dec_ovf = 1'b1; end
                    6'h23: dec_ctrl = OP_SUB;
                    6'h24: dec_ctrl = OP_AND;
                    6'h25: dec_ctrl = OP_OR;
                    6'h2A: dec_ctrl = OP_SLT;
                    6'h00: dec_ctrl = OP_SLL;
                    6'h02: dec_ctrl = OP_SRL;
                    6'h03: dec_ctrl = OP_SRA;
                    6'h04: begin dec_ctrl = OP_SLL; dec_shamt = rs_data[4:0]; end
                    6'h06: begin dec_ctrl = OP_SRL; dec_shamt = rs_data[4:0]; end
                    6'h07: begin dec_ctrl = OP_SRA; dec_shamt = rs_data[4:0]; end
                    default: legal = 1'b0;
                endcase
            end
            6'h08: begin dec_b = sign_ext(imm16); dec_ovf = 1'b1; end
            6'h09, 6'h23, 6'h2B: dec_b = sign_ext(imm16);
            6'h0A: begin dec_ctrl = OP_SLT; dec_b = sign_ext(imm16); end
            6'h0C: begin dec_ctrl = OP_AND; dec_b = zero_ext(imm16); end
            6'h0D: begin dec_ctrl = OP_OR;  dec_b = zero_ext(imm16); end
            // lui: ALU computes B << 16 with A forced to zero
            6'h0F: begin dec_ctrl = OP_LUI; dec_a = '0; dec_b = zero_ext(imm16); end
            6'h04, 6'h05: dec_ctrl = OP_SUB;
            default: legal = 1'b0;
        endcase
        dec_illegal = !legal;
        if (!legal) begin
            dec_ctrl  = OP_ADD;
            dec_a     = '0;
            dec_b     = '0;
            dec_shamt = 5'd0;
            dec_ovf   = 1'b0;
        end
    end

    logic signed [DATA_W-1:0] alu_a_p1, alu_b_p1;
    logic [CTRL_W-1:0]        ctrl_p1;
    logic [4:0]               shamt_p1;
    logic                     vld_p1, ovf_p1, ill_p1, ill_seen_p1;
    logic                     load_real;

    assign load_real = id_valid;

    // Stage p1: ID/EX register; priority reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_p1    <= '0;
            alu_b_p1    <= '0;
            ctrl_p1     <= '0;
            shamt_p1    <= '0;
            vld_p1      <= 1'b0;
            ovf_p1      <= 1'b0;
            ill_p1      <= 1'b0;
            ill_seen_p1 <= 1'b0;
        end else if (flush) begin
            alu_a_p1 <= '0;
            alu_b_p1 <= '0;
            ctrl_p1  <= '0;
            shamt_p1 <= '0;
            vld_p1   <= 1'b0;
            ovf_p1   <= 1'b0;
            ill_p1   <= 1'b0;
        end else if (!stall) begin
            vld_p1   <= load_real;
            alu_a_p1 <= load_real ? dec_a : '0;
            alu_b_p1 <= load_real ? dec_b : '0;
            ctrl_p1  <= load_real ? dec_ctrl : '0;
            shamt_p1 <= load_real ? dec_shamt : 5'd0;
            ovf_p1   <= load_real & dec_ovf;
            ill_p1   <= load_real & dec_illegal;
            if (load_real && dec_illegal)
                ill_seen_p1 <= 1'b1;
            else if (clr_illegal)
                ill_seen_p1 <= 1'b0;
        end
    end

    assign ALU_A        = alu_a_p1;
    assign ALU_B        = alu_b_p1;
    assign ALU_Control  = ctrl_p1;
    assign shamt        = shamt_p1;
    assign ex_valid     = vld_p1;
    assign ovf_en       = ovf_p1;
    assign illegal      = ill_p1;
    assign illegal_seen = ill_seen_p1;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a rule-table reference model predicts the
// registered outputs per edge; a monitor compares them one cycle after each edge.
module tb_alu_issue_stage;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  shamt;
        logic        vld;
        logic        ovf;
        logic        ill;
        logic        seen;
    } exp_t;

    // amode: 0 rs, 1 zero; bmode: 0 rt, 1 sign-ext, 2 zero-ext; smode: 0 zero, 1 shamt_in, 2 rs[4:0]
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
        int         amode;
        int         bmode;
        int         smode;
        logic       ovf;
    } rule_t;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, stall, flush, clr_illegal;
    logic [5:0]  opcode, funct;
    logic [4:0]  shamt_in, shamt;
    logic [15:0] imm16;
    logic [31:0] rs_data, rt_data, ALU_A, ALU_B;
    logic [3:0]  ALU_Control;
    logic        ex_valid, ovf_en, illegal, illegal_seen;

    alu_issue_stage #(.DATA_W(32), .CTRL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .shamt_in(shamt_in), .imm16(imm16), .rs_data(rs_data), .rt_data(rt_data),
        .stall(stall), .flush(flush), .clr_illegal(clr_illegal),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Control(ALU_Control), .shamt(shamt),
        .ex_valid(ex_valid), .ovf_en(ovf_en), .illegal(illegal), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    rule_t rules[23];
    exp_t  st;
    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    passed = 0;

    initial begin
        rules[0]  = '{6'h00, 6'h20, 4'd0, 0, 0, 1, 1'b1};
        rules[1]  = '{6'h00, 6'h21, 4'd0, 0, 0, 1, 1'b0};
        rules[2]  = '{6'h00, 6'h22, 4'd1, 0, 0, 1, 1'b1};
        rules[3]  = '{6'h00, 6'h23, 4'd1, 0, 0, 1, 1'b0};
        rules[4]  = '{6'h00, 6'h24, 4'd2, 0, 0, 1, 1'b0};
        rules[5]  = '{6'h00, 6'h25, 4'd3, 0, 0, 1, 1'b0};
        rules[6]  = '{6'h00, 6'h2A, 4'd8, 0, 0, 1, 1'b0};
        rules[7]  = '{6'h00, 6'h00, 4'd4, 0, 0, 1, 1'b0};
        rules[8]  = '{6'h00, 6'h02, 4'd5, 0, 0, 1, 1'b0};
        rules[9]  = '{6'h00, 6'h03, 4'd6, 0, 0, 1, 1'b0};
        rules[10] = '{6'h00, 6'h04, 4'd4, 0, 0, 2, 1'b0};
        rules[11] = '{6'h00, 6'h06, 4'd5, 0, 0, 2, 1'b0};
        rules[12] = '{6'h00, 6'h07, 4'd6, 0, 0, 2, 1'b0};
        rules[13] = '{6'h08, 6'h00, 4'd0, 0, 1, 0, 1'b1};
        rules[14] = '{6'h09, 6'h00, 4'd0, 0, 1, 0, 1'b0};
        rules[15] = '{6'h23, 6'h00, 4'd0, 0, 1, 0, 1'b0};
        rules[16] = '{6'h2B, 6'h00, 4'd0, 0, 1, 0, 1'b0};
        rules[17] = '{6'h0A, 6'h00, 4'd8, 0, 1, 0, 1'b0};
        rules[18] = '{6'h0C, 6'h00, 4'd2, 0, 2, 0, 1'b0};
        rules[19] = '{6'h0D, 6'h00, 4'd3, 0, 2, 0, 1'b0};
        rules[20] = '{6'h0F, 6'h00, 4'd7, 1, 2, 0, 1'b0};
        rules[21] = '{6'h04, 6'h00, 4'd1, 0, 0, 0, 1'b0};
        rules[22] = '{6'h05, 6'h00, 4'd1, 0, 0, 0, 1'b0};
    end

    // Decoded instruction as the EX stage should see it; ill=1 with zeroed fields when no rule matches.
    function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] sh, input logic [15:0] imm,
                                        input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        e = '0;
        e.vld = 1'b1;
        e.ill = 1'b1;
        foreach (rules[i]) begin
            if (rules[i].op == op && (op != 6'h00 || rules[i].fn == fn)) begin
                e.ill  = 1'b0;
                e.ctrl = rules[i].ctrl;
                e.ovf  = rules[i].ovf;
                e.a    = (rules[i].amode == 1) ? 32'h0 : rs;
                case (rules[i].bmode)
                    1:       e.b = 32'($signed(imm));
                    2:       e.b = {16'h0, imm};
                    default: e.b = rt;
                endcase
                case (rules[i].smode)
                    1:       e.shamt = sh;
                    2:       e.shamt = rs[4:0];
                    default: e.shamt = 5'd0;
                endcase
            end
        end
        return e;
    endfunction

    // Apply inputs for the next edge, predict the state after it, then wait for the negedge.
    task automatic step(input string tag, input logic r_n, input logic vld,
                        input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                        input logic stl, input logic fl, input logic clr);
        exp_t d;
        logic seen;
        rst_n = r_n; id_valid = vld; opcode = op; funct = fn; shamt_in = sh; imm16 = imm;
        rs_data = rs; rt_data = rt; stall = stl; flush = fl; clr_illegal = clr;
        seen = st.seen;
        if (!r_n) begin
            st = '0;
        end else if (fl) begin
            st = '0;
            st.seen = seen;
        end else if (!stl) begin
            d = vld ? ref_decode(op, fn, sh, imm, rs, rt) : exp_t'(0);
            if (d.ill) d.seen = 1'b1;
            else if (clr) d.seen = 1'b0;
            else d.seen = seen;
            st = d;
        end
        exp_q.push_back(st);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t  act, e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                act = '{ALU_A, ALU_B, ALU_Control, shamt, ex_valid, ovf_en, illegal, illegal_seen};
                checks++;
                if (act === e) passed++;
                else $display("FAIL %s: got A=%h B=%h ctl=%h sh=%h v=%b ovf=%b ill=%b seen=%b, want A=%h B=%h ctl=%h sh=%h v=%b ovf=%b ill=%b seen=%b",
                              t, act.a, act.b, act.ctrl, act.shamt, act.vld, act.ovf, act.ill, act.seen,
                              e.a, e.b, e.ctrl, e.shamt, e.vld, e.ovf, e.ill, e.seen);
            end
        end
    end

    logic [5:0] lop[11] = '{6'h00, 6'h08, 6'h09, 6'h23, 6'h2B, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05};
    logic [5:0] lfn[13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    initial begin : stim
        logic [5:0] op, fn;
        logic       r_n, stl, fl, clr, vld;
        st = '0;
        step("reset0", 0, 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h7FFFFFFF, 32'h1, 0, 0, 0);
        step("reset1", 0, 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h7FFFFFFF, 32'h1, 0, 0, 0);
        step("add",    1, 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h7FFFFFFF, 32'h1, 0, 0, 0);
        step("addu",   1, 1, 6'h00, 6'h21, 5'd0, 16'h0, 32'h7FFFFFFF, 32'h1, 0, 0, 0);
        step("addi",   1, 1, 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h10, 32'h0, 0, 0, 0);
        step("andi",   1, 1, 6'h0C, 6'h00, 5'd0, 16'hFFFF, 32'h10, 32'h0, 0, 0, 0);
        step("lui",    1, 1, 6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEADBEEF, 32'h0, 0, 0, 0);
        step("sra",    1, 1, 6'h00, 6'h03, 5'd4, 16'h0, 32'h1, 32'h80000000, 0, 0, 0);
        step("srav",   1, 1, 6'h00, 6'h07, 5'd9, 16'h0, 32'h25, 32'hCAFE0000, 0, 0, 0);
        step("sub",    1, 1, 6'h00, 6'h22, 5'd0, 16'h0, 32'h5, 32'h3, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 1, 6'h0D, 6'h00, 5'd1, 16'hAAAA, 32'h1111, 32'h2222, 1, 0, 0);
        step("flush+stall", 1, 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h1, 32'h1, 1, 1, 0);
        step("illegal",  1, 1, 6'h3F, 6'h00, 5'd3, 16'h1, 32'h9, 32'h9, 0, 0, 0);
        step("legal_after_ill", 1, 1, 6'h00, 6'h25, 5'd0, 16'h0, 32'h3, 32'h4, 0, 0, 0);
        step("clr_illegal", 1, 1, 6'h00, 6'h24, 5'd0, 16'h0, 32'h3, 32'h4, 0, 0, 1);
        step("clr_with_ill", 1, 1, 6'h00, 6'h3F, 5'd0, 16'h0, 32'h3, 32'h4, 0, 0, 1);
        step("stall_reset", 1, 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h3, 32'h4, 1, 0, 0);
        step("reset_mid_stall", 0, 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'h3, 32'h4, 1, 0, 0);
        step("bubble_ill_op", 1, 0, 6'h3F, 6'h3F, 5'd7, 16'h7, 32'h3, 32'h4, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            op  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : lop[$urandom_range(0, 10)];
            fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : lfn[$urandom_range(0, 12)];
            r_n = ($urandom_range(0, 49) != 0);
            fl  = ($urandom_range(0, 11) == 0);
            stl = ($urandom_range(0, 5) == 0);
            vld = ($urandom_range(0, 7) != 0);
            clr = (!fl && !stl && vld && $urandom_range(0, 7) == 0);
            step("random", r_n, vld, op, fn, 5'($urandom), 16'($urandom), $urandom, $urandom, stl, fl, clr);
        end
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
